// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//   Shares one serial pattern-detector engine between NREQ requesters.
//   A round-robin arbiter picks one requester per frame. The granted
//   requester's qualified bits are shifted into a history window and
//   compared against a configurable pattern (overlapping matches). The
//   frame ends after cfg_frame_len accepted bits, or early (abort) if the
//   requester drops req.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   req            per-requester frame request (level, held until done)
//   bit_in         per-requester serial data bit
//   bit_valid      per-requester bit qualifier
//   cfg_we         config write strobe (accepted only while idle)
//   cfg_pattern    pattern; bit [plen-1] is the oldest bit, bit 0 the newest
//   cfg_plen       pattern length; 0 disables detection, 9..15 act as 8
//   cfg_frame_len  bits per frame (0 ends the frame on the first scan cycle)
//   gnt            registered one-hot grant, zero outside a frame
//   match          one-cycle pulse per detected occurrence
//   match_cnt      saturating match count of the current/last frame
//   done           one-cycle pulse at frame end
//   done_id        requester whose frame ended, held until the next done
//   abort          qualifies done: frame ended because req dropped
//   busy           high whenever the engine is not idle
module seq_detect_scheduler #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  input  logic [NREQ-1:0] bit_valid,
  input  logic            cfg_we,
  input  logic [7:0]      cfg_pattern,
  input  logic [3:0]      cfg_plen,
  input  logic [7:0]      cfg_frame_len,
  output logic [NREQ-1:0] gnt,
  output logic            match,
  output logic [7:0]      match_cnt,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic            abort,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lengths above 8 behave as a full 8-bit window.
  function automatic logic [3:0] eff_plen(input logic [3:0] plen);
    logic [3:0] r;
    if (plen > 4'd8) r = 4'd8;
    else             r = plen;
    return r;
  endfunction

  // Mask selecting the newest 'len' bits of the window (len 0..8).
  function automatic logic [7:0] window_mask(input logic [3:0] len);
    return 8'hFF >> (4'd8 - len);
  endfunction

  state_t          state_r, state_s;
  logic [IDW-1:0]  id_r, id_n;
  logic [IDW-1:0]  last_r, last_n;
  logic [7:0]      bit_cnt_r, bit_cnt_n;
  // The oldest bit of the 8-bit window is only needed combinationally,
  // so seven bits are stored and the incoming bit completes the window.
  logic [6:0]      hist_r, hist_n;
  logic [7:0]      cfg_pattern_r;
  logic [3:0]      cfg_plen_r;
  logic [7:0]      cfg_frame_len_r;

  logic [NREQ-1:0] gnt_r, gnt_n;
  logic            match_r, match_n;
  logic [7:0]      match_cnt_r, match_cnt_n;
  logic            done_r, done_n;
  logic [IDW-1:0]  done_id_r, done_id_n;
  logic            abort_r, abort_n;
  logic            busy_r, busy_n;

  logic            win_found_s;
  logic [IDW-1:0]  win_id_s;
  int              idx_s;
  logic            req_id_s, valid_id_s, bit_id_s;
  logic            accept_s, frame_end_s, hit_s;
  logic [7:0]      window_s;
  logic [7:0]      cnt_inc_s;
  logic [3:0]      plen_eff_s;

  // Round-robin search starting at the requester after the last grant.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    idx_s       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = int'(last_r) + 1 + k;
      if (idx_s >= NREQ) idx_s = idx_s - NREQ;
      else               idx_s = idx_s;
      if (!win_found_s && req[IDW'(idx_s)]) begin
        win_found_s = 1'b1;
        win_id_s    = IDW'(idx_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Granted requester's inputs, bit acceptance and pattern comparison.
  always_comb begin
    req_id_s    = req[id_r];
    valid_id_s  = bit_valid[id_r];
    bit_id_s    = bit_in[id_r];
    // A zero-length frame accepts nothing; it closes on its first scan cycle.
    accept_s    = (state_r == ST_SCAN) && req_id_s && valid_id_s &&
                  (cfg_frame_len_r != 8'd0);
    window_s    = {hist_r, bit_id_s};
    cnt_inc_s   = bit_cnt_r + 8'd1;
    plen_eff_s  = eff_plen(cfg_plen_r);
    hit_s       = (cfg_plen_r != 4'd0) &&
                  (cnt_inc_s >= {4'd0, plen_eff_s}) &&
                  (((window_s ^ cfg_pattern_r) & window_mask(plen_eff_s)) == 8'd0);
    if (cfg_frame_len_r == 8'd0) frame_end_s = 1'b1;
    else                         frame_end_s = accept_s && (cnt_inc_s == cfg_frame_len_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) state_s = ST_SCAN;
        else             state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (!req_id_s)        state_s = ST_DONE;
        else if (frame_end_s) state_s = ST_DONE;
        else                  state_s = ST_SCAN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    gnt_n       = gnt_r;
    match_n     = 1'b0;
    match_cnt_n = match_cnt_r;
    done_n      = 1'b0;
    done_id_n   = done_id_r;
    abort_n     = 1'b0;
    busy_n      = (state_s != ST_IDLE);
    bit_cnt_n   = bit_cnt_r;
    hist_n      = hist_r;
    id_n        = id_r;
    last_n      = last_r;
    case (state_r)
      ST_IDLE: begin
        gnt_n = '0;
        if (win_found_s) begin
          gnt_n[win_id_s] = 1'b1;
          id_n        = win_id_s;
          last_n      = win_id_s;
          bit_cnt_n   = 8'd0;
          hist_n      = 7'd0;
          match_cnt_n = 8'd0;
        end else begin
          id_n = id_r;
        end
      end
      ST_SCAN: begin
        if (accept_s) begin
          hist_n    = window_s[6:0];
          bit_cnt_n = cnt_inc_s;
          if (hit_s) begin
            match_n = 1'b1;
            if (match_cnt_r != 8'hFF) match_cnt_n = match_cnt_r + 8'd1;
            else                      match_cnt_n = match_cnt_r;
          end else begin
            match_n = 1'b0;
          end
        end else begin
          hist_n = hist_r;
        end
        if (state_s == ST_DONE) begin
          gnt_n     = '0;
          done_n    = 1'b1;
          done_id_n = id_r;
          abort_n   = !req_id_s;
        end else begin
          gnt_n = gnt_r;
        end
      end
      ST_DONE: gnt_n = '0;
      default: gnt_n = '0;
    endcase
  end

  // Output, history and arbitration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_r       <= '0;
      match_r     <= 1'b0;
      match_cnt_r <= 8'd0;
      done_r      <= 1'b0;
      done_id_r   <= '0;
      abort_r     <= 1'b0;
      busy_r      <= 1'b0;
      bit_cnt_r   <= 8'd0;
      hist_r      <= 7'd0;
      id_r        <= '0;
      // Pointing at the last requester makes requester 0 win first.
      last_r      <= IDW'(NREQ - 1);
    end else begin
      gnt_r       <= gnt_n;
      match_r     <= match_n;
      match_cnt_r <= match_cnt_n;
      done_r      <= done_n;
      done_id_r   <= done_id_n;
      abort_r     <= abort_n;
      busy_r      <= busy_n;
      bit_cnt_r   <= bit_cnt_n;
      hist_r      <= hist_n;
      id_r        <= id_n;
      last_r      <= last_n;
    end
  end

  // Configuration is captured only while idle so a running frame is stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pattern_r   <= 8'b0000_0101;
      cfg_plen_r      <= 4'd3;
      cfg_frame_len_r <= 8'd8;
    end else if (cfg_we && (state_r == ST_IDLE)) begin
      cfg_pattern_r   <= cfg_pattern;
      cfg_plen_r      <= cfg_plen;
      cfg_frame_len_r <= cfg_frame_len;
    end else begin
      cfg_pattern_r   <= cfg_pattern_r;
      cfg_plen_r      <= cfg_plen_r;
      cfg_frame_len_r <= cfg_frame_len_r;
    end
  end

  assign gnt       = gnt_r;
  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign abort     = abort_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed testbench for seq_detect_scheduler (NREQ = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_seq_detect_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, bit_in, bit_valid;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_plen;
  logic [7:0] cfg_frame_len;
  logic [3:0] gnt;
  logic       match;
  logic [7:0] match_cnt;
  logic       done;
  logic [1:0] done_id;
  logic       abort;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_scheduler #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_plen(cfg_plen),
    .cfg_frame_len(cfg_frame_len), .gnt(gnt), .match(match),
    .match_cnt(match_cnt), .done(done), .done_id(done_id), .abort(abort),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input logic [3:0] pl, input logic [7:0] fl);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_plen = pl; cfg_frame_len = fl;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0; bit_in = 4'b0; bit_valid = 4'b0;
    cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_plen = 4'd0; cfg_frame_len = 8'd0;
    step(); step();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL rst_match: got %b want 0", match); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL rst_match_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (done_id !== 2'd0) begin n_err++; $display("FAIL rst_done_id: got %0d want 0", done_id); end
    n_cmp++; if (abort !== 1'b0) begin n_err++; $display("FAIL rst_abort: got %b want 0", abort); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b1;
  endtask

  // Default config, stream 1,0,1,0,1,1,0,1: matches after bits 3, 5 and 8.
  task automatic test_basic();
    logic [7:0] bits_v, exp_v;
    bits_v = 8'b1010_1101;
    exp_v  = 8'b0010_1001;
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL basic_gnt: got %b want 0001", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      bit_valid = 4'b0001;
      bit_in = {3'b000, bits_v[7]};
      step();
      n_cmp++; if (match !== exp_v[7]) begin n_err++; $display("FAIL basic_match_bit%0d: got %b want %b", i + 1, match, exp_v[7]); end
      bits_v = bits_v << 1;
      exp_v  = exp_v << 1;
    end
    bit_valid = 4'b0000;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (done_id !== 2'd0) begin n_err++; $display("FAIL basic_done_id: got %0d want 0", done_id); end
    n_cmp++; if (abort !== 1'b0) begin n_err++; $display("FAIL basic_abort: got %b want 0", abort); end
    n_cmp++; if (match_cnt !== 8'd3) begin n_err++; $display("FAIL basic_match_cnt: got %0d want 3", match_cnt); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL basic_gnt_done: got %b want 0000", gnt); end
    req = 4'b0000;
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    n_cmp++; if (match_cnt !== 8'd3) begin n_err++; $display("FAIL basic_cnt_hold: got %0d want 3", match_cnt); end
  endtask

  // All requesters held high after reset: grants 0,1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] one_v;
    one_v = 4'b0001;
    rst = 1'b0;
    step();
    rst = 1'b1; req = 4'b1111; bit_valid = 4'b1111; bit_in = 4'b0000;
    for (int f = 0; f < 5; f++) begin
      step();
      n_cmp++; if (gnt !== (one_v << (f % 4))) begin n_err++; $display("FAIL rr_gnt_f%0d: got %b want %b", f, gnt, one_v << (f % 4)); end
      for (int b = 1; b <= 8; b++) step();
      n_cmp++; if (done !== 1'b1 || done_id !== 2'(f % 4)) begin n_err++; $display("FAIL rr_done_f%0d: got done=%b id=%0d want done=1 id=%0d", f, done, done_id, f % 4); end
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rr_gnt_done_f%0d: got %b want 0000", f, gnt); end
      step();
      n_cmp++; if (gnt !== 4'b0000 || done !== 1'b0) begin n_err++; $display("FAIL rr_idle_f%0d: got gnt=%b done=%b want 0000/0", f, gnt, done); end
    end
    req = 4'b0000; bit_valid = 4'b0000;
  endtask

  // plen 4, pattern 1111, frame 10 all ones: 7 overlapping matches.
  task automatic test_overlap();
    int nm, first;
    nm = 0; first = 0;
    write_cfg(8'h0F, 4'd4, 8'd10);
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ovl_gnt: got %b want 0001", gnt); end
    bit_in = 4'b0001; bit_valid = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (match === 1'b1) begin
        nm++;
        if (first == 0) first = i;
      end
    end
    n_cmp++; if (first != 4) begin n_err++; $display("FAIL ovl_first: got bit %0d want bit 4", first); end
    n_cmp++; if (nm != 7) begin n_err++; $display("FAIL ovl_pulses: got %0d want 7", nm); end
    n_cmp++; if (match_cnt !== 8'd7) begin n_err++; $display("FAIL ovl_match_cnt: got %0d want 7", match_cnt); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ovl_done: got %b want 1", done); end
    req = 4'b0000; bit_valid = 4'b0000; bit_in = 4'b0000;
    step();
  endtask

  // req2 drops after 3 bits; the 4th bit (which would complete 1111) is ignored.
  task automatic test_abort();
    req = 4'b0100; bit_valid = 4'b0100; bit_in = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL abort_gnt: got %b want 0100", gnt); end
    step(); step(); step();
    req = 4'b0000;
    step();
    n_cmp++; if (done !== 1'b1 || abort !== 1'b1) begin n_err++; $display("FAIL abort_flags: got done=%b abort=%b want 1/1", done, abort); end
    n_cmp++; if (done_id !== 2'd2) begin n_err++; $display("FAIL abort_done_id: got %0d want 2", done_id); end
    n_cmp++; if (match !== 1'b0 || match_cnt !== 8'd0) begin n_err++; $display("FAIL abort_ignored_bit: got match=%b cnt=%0d want 0/0", match, match_cnt); end
    req = 4'b1011; bit_valid = 4'b0000; bit_in = 4'b0000;
    step();
    n_cmp++; if (gnt !== 4'b0000 || abort !== 1'b0) begin n_err++; $display("FAIL abort_idle: got gnt=%b abort=%b want 0000/0", gnt, abort); end
    step();
    n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL abort_next_rr: got %b want 1000", gnt); end
    req = 4'b0000;
    step();
    n_cmp++; if (done !== 1'b1 || abort !== 1'b1 || done_id !== 2'd3) begin n_err++; $display("FAIL abort_second: got done=%b abort=%b id=%0d want 1/1/3", done, abort, done_id); end
    step();
  endtask

  // Config writes during a frame must not change it.
  task automatic test_cfg_in_scan();
    logic [7:0] bits_v;
    bits_v = 8'b1010_1101;
    write_cfg(8'h05, 4'd3, 8'd8);
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL cfgscan_gnt: got %b want 0001", gnt); end
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_plen = 4'd1; cfg_frame_len = 8'd2;
    bit_valid = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      bit_in = {3'b000, bits_v[7]};
      bits_v = bits_v << 1;
      step();
      cfg_we = 1'b0;
      if (i == 2) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cfgscan_early_done: got %b want 0", done); end
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cfgscan_done8: got %b want 1", done); end
    n_cmp++; if (match_cnt !== 8'd3) begin n_err++; $display("FAIL cfgscan_match_cnt: got %0d want 3", match_cnt); end
    req = 4'b0000; bit_valid = 4'b0000; bit_in = 4'b0000;
    step();
  endtask

  // Zero frame length: done after a single scan cycle, match_cnt cleared.
  task automatic test_frame_len_zero();
    write_cfg(8'h05, 4'd3, 8'd0);
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001 || busy !== 1'b1) begin n_err++; $display("FAIL zero_gnt: got gnt=%b busy=%b want 0001/1", gnt, busy); end
    step();
    n_cmp++; if (done !== 1'b1 || abort !== 1'b0) begin n_err++; $display("FAIL zero_done: got done=%b abort=%b want 1/0", done, abort); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL zero_match_cnt: got %0d want 0", match_cnt); end
    req = 4'b0000;
    step();
  endtask

  // Reset mid-frame clears outputs without a clock edge; config returns to default.
  task automatic test_async_reset();
    write_cfg(8'h05, 4'd3, 8'd8);
    req = 4'b0010;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL arst_gnt: got %b want 0010", gnt); end
    bit_valid = 4'b0010;
    bit_in = 4'b0010; step();
    bit_in = 4'b0000; step();
    bit_in = 4'b0010; step();
    n_cmp++; if (match !== 1'b1 || match_cnt !== 8'd1) begin n_err++; $display("FAIL arst_pre_match: got match=%b cnt=%0d want 1/1", match, match_cnt); end
    bit_valid = 4'b0000; bit_in = 4'b0000;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000 || match !== 1'b0 || match_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0 || done_id !== 2'd0) begin
      n_err++; $display("FAIL arst_outputs: got gnt=%b m=%b cnt=%0d busy=%b done=%b abort=%b id=%0d want all 0", gnt, match, match_cnt, busy, done, abort, done_id);
    end
    rst = 1'b1;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL arst_first_gnt: got %b want 0010", gnt); end
    bit_valid = 4'b0010;
    for (int i = 1; i <= 7; i++) step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_cfg_len7: got %b want 0", done); end
    step();
    n_cmp++; if (done !== 1'b1 || done_id !== 2'd1) begin n_err++; $display("FAIL arst_cfg_len8: got done=%b id=%0d want 1/1", done, done_id); end
    req = 4'b0000; bit_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_overlap();
    test_abort();
    test_cfg_in_scan();
    test_frame_len_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of serial requesters sharing the detector engine.
REQ-002 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  NREQ  per-requester frame-scan request, level, held high until done.
REQ-005 Port bit_in  input  NREQ  per-requester serial data bit.
REQ-006 Port bit_valid  input  NREQ  per-requester bit qualifier.
REQ-007 Port cfg_we  input  1  config write strobe, honoured only in IDLE.
REQ-008 Port cfg_pattern  input  8  pattern; bit [plen-1] is the first bit in time, bit 0 the last.
REQ-009 Port cfg_plen  input  4  pattern length; 0 disables detection; 9-15 act as 8.
REQ-010 Port cfg_frame_len  input  8  bits per frame, 0 to 255.
REQ-011 Port gnt  output  NREQ  registered one-hot grant, all-zero when no frame is active.
REQ-012 Port match  output  1  one-cycle pulse per detected pattern occurrence.
REQ-013 Port match_cnt  output  8  matches in the current or last frame, saturating at 255.
REQ-014 Port done  output  1  one-cycle pulse at frame end.
REQ-015 Port done_id  output  clog2(NREQ)  index of the requester whose frame ended, held until the next done.
REQ-016 Port abort  output  1  qualifies done: frame ended early because req dropped.
REQ-017 Port busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-019 IDLE, any req high: select a winner round-robin, starting from the index after the last granted one.
  - Assert gnt[winner] and clear bit_cnt, history and match_cnt on the same edge.
  - Enter SCAN.
REQ-020 IDLE, no req: remain in IDLE with gnt=0.
REQ-021 In SCAN, a bit is accepted on each cycle where bit_valid[id] is high; bits from non-granted requesters are ignored.
REQ-022 Each accepted bit SHALL be shifted into an 8-bit history at LSB and increment bit_cnt.
REQ-023 Match condition: detection enabled, accepted bits in this frame >= plen, and the last plen history bits equal cfg_pattern[plen-1:0].
  - Detection is overlapping.
  - match pulses on the edge that accepts the completing bit, i.e. visible the cycle after bit_valid.
  - match_cnt increments on the same edge.
REQ-024 SCAN to DONE when bit_cnt reaches cfg_frame_len after an accepted bit.
  - With cfg_frame_len = 0, go to DONE on the first SCAN cycle with no bit accepted.
REQ-025 SCAN, req[id] low: go to DONE with abort=1; a bit_valid in that cycle SHALL be ignored.
REQ-026 DONE lasts exactly one cycle.
  - Outputs: done=1, done_id=id, gnt=0.
  - match_cnt holds its final value.
  - Then go to IDLE; the earliest next grant is on the following edge.
REQ-027 cfg_we outside IDLE SHALL be ignored; config in use is the value latched at the last accepted write.
REQ-028 match_cnt SHALL saturate at 255 and never wrap.

Reset
REQ-029 rst low SHALL immediately force IDLE, regardless of clk, including mid-frame.
REQ-030 Reset values of outputs:
  - gnt=0, match=0, match_cnt=0, done=0, done_id=0, abort=0, busy=0.
REQ-031 Reset values of internal state:
  - bit_cnt=0, history=0, round-robin pointer such that requester 0 wins first.
  - cfg_pattern=8'b00000101, cfg_plen=3, cfg_frame_len=8.
REQ-032 After rst rises, the first grant can occur on the first rising edge with req set.

Verification
REQ-033 Default config; req0, bits 1,0,1,0,1,1,0,1 -> match after bits 3, 5 and 8; done, done_id=0, match_cnt=3, abort=0.
REQ-034 req=4'b1111 held, default config -> grant order 0,1,2,3,0; each gnt one-hot with exactly one DONE cycle between frames.
REQ-035 cfg_plen=4, cfg_pattern=8'h0F, frame_len=10, all-ones stream -> 7 match pulses, match_cnt=7.
REQ-036 req2 drops after 3 accepted bits -> next cycle done=1, abort=1, done_id=2; next grant obeys round-robin from 3.
REQ-037 cfg_we in SCAN with frame_len=2 -> frame still ends after 8 bits; rst low mid-frame -> all outputs 0 asynchronously; cfg_frame_len=0 -> done after one SCAN cycle with match_cnt=0.
